// File: rtl/unified_mem_ctrl_if.sv
// Fetch and load/store bus of the unified memory controller.
// The core side drives requests and the memory side returns data and ready.
interface unified_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ready;
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  i_rdata, i_ready, d_rdata, d_ready
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_rdata, i_ready, d_rdata, d_ready
    );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified word-organised memory shared by a fetch port and a load/store port.
// One transaction at a time: IDLE -> WAIT (LATENCY cycles) -> RESP.
// Data wins contests, except that a fetch which already lost once to data
// is granted next, so fetch never waits more than one data transaction.
module unified_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    unified_mem_ctrl_if.slave   bus,
    output logic                busy
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Everything a transaction needs, captured at grant.
    typedef struct packed {
        logic              dport;
        logic              we;
        logic [NB-1:0]     be;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_t             state_q, state_d;
    txn_t               txn_q, txn_new, txn_cur;
    logic [2:0]         cnt_q;
    logic               last_data_q;
    logic               pend_q;
    logic               grant, grant_d;
    logic               enter_resp;
    logic [DATA_W-1:0]  cur_word, merged;
    logic [DATA_W-1:0]  i_rdata_q, d_rdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Address bits outside the word index are deliberately ignored.
    logic addr_unused;
    assign addr_unused = ^{bus.i_addr, bus.d_addr};

    // Arbitration and the candidate transaction built from live inputs.
    always_comb begin
        grant   = bus.d_req || bus.i_req;
        grant_d = 1'b0;
        if (bus.d_req && bus.i_req)
            grant_d = !(last_data_q && pend_q);
        else
            grant_d = bus.d_req;
        txn_new.dport = grant_d;
        txn_new.we    = grant_d && bus.d_we;
        txn_new.be    = bus.d_be;
        txn_new.idx   = grant_d ? bus.d_addr[IDX_W+1:2] : bus.i_addr[IDX_W+1:2];
        txn_new.wdata = bus.d_wdata;
    end

    // Next state; enter_resp marks the edge on which the array is accessed.
    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the grant edge itself,
    // so the live candidate is used instead of the latched copy.
    always_comb begin
        txn_cur  = (state_q == IDLE) ? txn_new : txn_q;
        cur_word = mem[txn_cur.idx];
        merged   = cur_word;
        for (int k = 0; k < NB; k++)
            if (txn_cur.we && txn_cur.be[k])
                merged[8*k +: 8] = txn_cur.wdata[8*k +: 8];
    end

    // Control state, latched transaction, arbitration history, read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            cnt_q       <= 3'd0;
            last_data_q <= 1'b0;
            pend_q      <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant) begin
                txn_q       <= txn_new;
                cnt_q       <= CNT_INIT;
                last_data_q <= grant_d;
                pend_q      <= grant_d && bus.i_req;
            end else if (state_q == WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (enter_resp) begin
                if (txn_cur.dport)
                    d_rdata_q <= merged;
                else
                    i_rdata_q <= cur_word;
            end
        end
    end

    // Array write; merged equals the current word on lanes with be clear.
    always_ff @(posedge clk) begin
        if (enter_resp && txn_cur.we && !reset)
            mem[txn_cur.idx] <= merged;
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ready = (state_q == RESP) && !txn_q.dport;
    assign bus.d_ready = (state_q == RESP) && txn_q.dport;
    assign busy        = (state_q != IDLE);
endmodule
